// File: rtl/ff_pkg.sv
// ---------------------------------------------------------------------------
// ff_pkg: state encoding and sizing helper shared by input-conditioning logic
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ff_pkg;

  localparam logic [1:0] ST_S0 = 2'd0;
  localparam logic [1:0] ST_W1 = 2'd1;
  localparam logic [1:0] ST_S1 = 2'd2;
  localparam logic [1:0] ST_W0 = 2'd3;

  typedef enum logic [1:0] {
    S0 = ST_S0,
    W1 = ST_W1,
    S1 = ST_S1,
    W0 = ST_W0
  } state_e;

  function automatic int cnt_width(input int stable_cnt);
    return $clog2(stable_cnt + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_chain.sv
// ---------------------------------------------------------------------------
// sync_chain: N-stage asynchronous-reset D-FF synchroniser for a single pin
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_chain #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic res,
  input  logic d,
  output logic q
);

  logic [N-1:0] stage_q;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[N-2:0], d};
    end
  end

  assign q = stage_q[N-1];

endmodule

`default_nettype wire

// File: rtl/debounce_edge.sv
// ---------------------------------------------------------------------------
// debounce_edge: synchronise and debounce a mechanical pin, emitting a clean
// level plus single-cycle rise/fall pulses.  Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module debounce_edge
  import ff_pkg::*;
#(
  parameter int STABLE_CNT  = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic res,
  input  logic btn_in,
  output logic btn_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int              CNT_W    = cnt_width(STABLE_CNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  logic             s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_q, btn_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  sync_chain #(
    .N (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .res (res),
    .d   (btn_in),
    .q   (s)
  );

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= S0;
      cnt_q   <= '0;
      btn_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      btn_q   <= btn_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Entering a wait state counts as the first new-level sample, so acceptance
  // happens on the sample where the counter has already reached STABLE_CNT-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    btn_d   = btn_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      S0: begin
        if (s) begin
          state_d = W1;
          cnt_d   = '0;
        end
      end
      W1: begin
        if (!s) begin
          state_d = S0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S1;
          btn_d   = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S1: begin
        if (!s) begin
          state_d = W0;
          cnt_d   = '0;
        end
      end
      W0: begin
        if (s) begin
          state_d = S1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S0;
          btn_d   = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S0;
    endcase
  end

  assign btn_o  = btn_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

`default_nettype wire

// File: tb/tb_debounce_edge.sv
// ---------------------------------------------------------------------------
// tb_debounce_edge: directed scenarios with a per-edge scoreboard on
// {btn_o, rise_o, fall_o}.  Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_debounce_edge;

  localparam int STABLE = 4;
  localparam int SYNC   = 2;

  logic clk = 1'b0;
  logic res = 1'b0;
  logic btn_in = 1'b0;
  logic btn_o, rise_o, fall_o;

  int errors = 0;
  int checks = 0;

  logic [2:0] exp_q[$];
  logic       hist[SYNC] = '{default: 1'b0};
  logic       lvl = 1'b0;
  int         run = 0;

  debounce_edge #(
    .STABLE_CNT  (STABLE),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk    (clk),
    .res    (res),
    .btn_in (btn_in),
    .btn_o  (btn_o),
    .rise_o (rise_o),
    .fall_o (fall_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Scoreboard: each drive pushes the outputs expected after the next edge.
  always @(posedge clk) begin
    logic [2:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({btn_o, rise_o, fall_o} !== e) begin
        errors++;
        $display("FAIL scoreboard t=%0t {btn,rise,fall} got=%b exp=%b", $time, {btn_o, rise_o, fall_o}, e);
      end
    end
  end

  // Reference: a level change is accepted once the synchronised view of the
  // pin has differed from the current level on STABLE+1 consecutive edges.
  task automatic drive(input logic v, input logic r);
    logic       s;
    logic [2:0] e;
    @(negedge clk);
    btn_in = v;
    res    = r;
    #1;
    if (!r) begin
      for (int i = 0; i < SYNC; i++) hist[i] = 1'b0;
      lvl = 1'b0;
      run = 0;
      e   = 3'b000;
    end else begin
      s = hist[0];
      for (int i = 0; i < SYNC - 1; i++) hist[i] = hist[i+1];
      hist[SYNC-1] = v;
      e = {lvl, 2'b00};
      if (s != lvl) begin
        run++;
        if (run == STABLE + 1) begin
          lvl = s;
          run = 0;
          e   = {s, s, ~s};
        end
      end else begin
        run = 0;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0);
      checks++;
      if ({btn_o, rise_o, fall_o} !== 3'b000) begin
        errors++;
        $display("FAIL reset_hold cycle %0d got=%b exp=000", i, {btn_o, rise_o, fall_o});
      end
    end
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1);
      checks++;
      if ({btn_o, rise_o, fall_o} !== 3'b000) begin
        errors++;
        $display("FAIL reset_release_idle cycle %0d got=%b exp=000", i, {btn_o, rise_o, fall_o});
      end
    end
  endtask

  task automatic test_clean_press();
    int falls = 0;
    for (int i = 1; i <= 7; i++) drive(1'b1, 1'b1);
    checks++;
    if ({btn_o, rise_o} !== 2'b00) begin
      errors++;
      $display("FAIL press_before_latency got btn,rise=%b exp=00", {btn_o, rise_o});
    end
    drive(1'b1, 1'b1);
    checks++;
    if ({btn_o, rise_o, fall_o} !== 3'b110) begin
      errors++;
      $display("FAIL press_accept got=%b exp=110", {btn_o, rise_o, fall_o});
    end
    drive(1'b1, 1'b1);
    checks++;
    if ({btn_o, rise_o} !== 2'b10) begin
      errors++;
      $display("FAIL press_pulse_end got btn,rise=%b exp=10", {btn_o, rise_o});
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1);
      if (fall_o) falls++;
    end
    checks++;
    if (falls != 0 || btn_o !== 1'b1) begin
      errors++;
      $display("FAIL press_hold got falls=%0d btn=%b exp falls=0 btn=1", falls, btn_o);
    end
  endtask

  task automatic test_clean_release();
    checks++;
    if (btn_o !== 1'b1) begin
      errors++;
      $display("FAIL release_precondition got btn=%b exp=1", btn_o);
    end
    for (int i = 1; i <= 7; i++) drive(1'b0, 1'b1);
    checks++;
    if ({btn_o, fall_o} !== 2'b10) begin
      errors++;
      $display("FAIL release_before_latency got btn,fall=%b exp=10", {btn_o, fall_o});
    end
    drive(1'b0, 1'b1);
    checks++;
    if ({btn_o, rise_o, fall_o} !== 3'b001) begin
      errors++;
      $display("FAIL release_accept got=%b exp=001", {btn_o, rise_o, fall_o});
    end
    drive(1'b0, 1'b1);
    checks++;
    if ({btn_o, fall_o} !== 2'b00) begin
      errors++;
      $display("FAIL release_pulse_width got btn,fall=%b exp=00", {btn_o, fall_o});
    end
  endtask

  task automatic test_glitch();
    int rises = 0;
    int falls = 0;
    int fall_at = 0;
    logic saw_btn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1);
      if (rise_o) rises++;
      if (btn_o) saw_btn = 1'b1;
    end
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b1);
      if (rise_o) rises++;
      if (fall_o) falls++;
      if (btn_o) saw_btn = 1'b1;
    end
    checks++;
    if (rises != 0 || falls != 0 || saw_btn) begin
      errors++;
      $display("FAIL glitch_4_rejected got rises=%0d falls=%0d btn_seen=%b exp 0 0 0", rises, falls, saw_btn);
    end
    rises = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1);
      if (rise_o) rises++;
    end
    for (int i = 1; i <= 12; i++) begin
      drive(1'b0, 1'b1);
      if (rise_o) rises++;
      if (fall_o) begin
        falls++;
        fall_at = i;
      end
    end
    checks++;
    if (rises != 1 || falls != 1) begin
      errors++;
      $display("FAIL glitch_5_accepted got rises=%0d falls=%0d exp 1 1", rises, falls);
    end
    checks++;
    if (fall_at != 8) begin
      errors++;
      $display("FAIL glitch_5_fall_time got drive=%0d exp=8", fall_at);
    end
  endtask

  task automatic test_reset_mid();
    int rise_at = 0;
    int rises = 0;
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    checks++;
    if ({btn_o, rise_o, fall_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_wait got=%b exp=000", {btn_o, rise_o, fall_o});
    end
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 1'b1);
      if (rise_o) begin
        rises++;
        rise_at = i;
      end
    end
    checks++;
    if (rises != 1 || rise_at != 8) begin
      errors++;
      $display("FAIL reset_mid_relatency got rises=%0d at drive=%0d exp 1 at 8", rises, rise_at);
    end
    drive(1'b1, 1'b0);
    checks++;
    if (btn_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_async_clear got btn=%b exp=0", btn_o);
    end
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1);
  endtask

  task automatic test_bounce();
    int rises = 0;
    int falls = 0;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      drive(((i / 2) % 2) == 0, 1'b1);
      if (rise_o) rises++;
      if (fall_o) falls++;
    end
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 1'b1);
      if (rise_o) rises++;
      if (fall_o) falls++;
    end
    checks++;
    if (rises != 1 || falls != 0 || btn_o !== 1'b1) begin
      errors++;
      $display("FAIL bounce got rises=%0d falls=%0d btn=%b exp 1 0 1", rises, falls, btn_o);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_clean_release();
    test_glitch();
    test_reset_mid();
    test_bounce();
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got pending=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
